// File: rtl/mu0_control_if.sv
// MU0 control-to-datapath bus: opcode and flags in, selects, enables,
// strobes and status out.
interface mu0_control_if #(
    parameter int CNT_W = 16
);
    logic [3:0]       F;
    logic             N;
    logic             Z;
    logic [1:0]       M;
    logic             X_sel;
    logic             Y_sel;
    logic             Addr_sel;
    logic             PC_En;
    logic             Acc_En;
    logic             IR_En;
    logic             Rd;
    logic             Wr;
    logic [1:0]       State;
    logic             Illegal;
    logic [CNT_W-1:0] Instr_Count;

    modport master (
        output F, N, Z,
        input  M, X_sel, Y_sel, Addr_sel,
        input  PC_En, Acc_En, IR_En, Rd, Wr,
        input  State, Illegal, Instr_Count
    );

    modport slave (
        input  F, N, Z,
        output M, X_sel, Y_sel, Addr_sel,
        output PC_En, Acc_En, IR_En, Rd, Wr,
        output State, Illegal, Instr_Count
    );
endinterface

// File: rtl/mu0_control.sv
// MU0 control unit: fetch/execute/halt FSM, opcode decode,
// sticky illegal flag and saturating instruction counter.
module mu0_control #(
    parameter int CNT_W = 16
) (
    input logic           Clk,
    input logic           nReset,
    mu0_control_if.slave  bus
);
    localparam logic [1:0] S_FETCH = 2'b00;
    localparam logic [1:0] S_EXEC  = 2'b01;
    localparam logic [1:0] S_HALT  = 2'b10;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_STA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_JMP = 4'h4;
    localparam logic [3:0] OP_JGE = 4'h5;
    localparam logic [3:0] OP_JNE = 4'h6;
    localparam logic [3:0] OP_STP = 4'h7;

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic             r_illegal;
    logic [CNT_W-1:0] r_cnt;
    logic             w_exec;

    logic [1:0]       w_m;
    logic             w_x_sel;
    logic             w_y_sel;
    logic             w_addr_sel;
    logic             w_pc_en;
    logic             w_acc_en;
    logic             w_ir_en;
    logic             w_rd;
    logic             w_wr;

    assign w_exec = (r_state == S_EXEC);

    always_ff @(posedge Clk) begin
        if (!nReset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = S_FETCH;
        unique case (r_state)
            S_FETCH: w_next = S_EXEC;
            S_EXEC: begin
                if (bus.F == OP_STP || bus.F[3]) begin
                    w_next = S_HALT;
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_HALT:  w_next = S_HALT;
            default: w_next = S_FETCH;
        endcase
    end

    // Every instruction leaves EXECUTE exactly once, so count there.
    always_ff @(posedge Clk) begin
        if (!nReset) begin
            r_illegal <= 1'b0;
            r_cnt     <= '0;
        end else if (w_exec) begin
            if (bus.F[3]) begin
                r_illegal <= 1'b1;
            end
            if (r_cnt != {CNT_W{1'b1}}) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_m        = 2'b00;
        w_x_sel    = 1'b0;
        w_y_sel    = 1'b0;
        w_addr_sel = 1'b0;
        w_pc_en    = 1'b0;
        w_acc_en   = 1'b0;
        w_ir_en    = 1'b0;
        w_rd       = 1'b0;
        w_wr       = 1'b0;
        if (nReset) begin
            unique case (r_state)
                S_FETCH: begin
                    w_rd    = 1'b1;
                    w_ir_en = 1'b1;
                    w_x_sel = 1'b1;
                    w_m     = 2'b10;
                    w_pc_en = 1'b1;
                end
                S_EXEC: begin
                    unique case (bus.F)
                        OP_LDA: begin
                            w_addr_sel = 1'b1;
                            w_rd       = 1'b1;
                            w_acc_en   = 1'b1;
                        end
                        OP_STA: begin
                            w_addr_sel = 1'b1;
                            w_wr       = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            w_addr_sel = 1'b1;
                            w_rd       = 1'b1;
                            w_acc_en   = 1'b1;
                            w_m        = bus.F[0] ? 2'b11 : 2'b01;
                        end
                        OP_JMP: begin
                            w_y_sel = 1'b1;
                            w_pc_en = 1'b1;
                        end
                        OP_JGE: begin
                            w_y_sel = !bus.N;
                            w_pc_en = !bus.N;
                        end
                        OP_JNE: begin
                            w_y_sel = !bus.Z;
                            w_pc_en = !bus.Z;
                        end
                        default: begin
                            w_m = 2'b00;
                        end
                    endcase
                end
                default: begin
                    w_m = 2'b00;
                end
            endcase
        end
    end

    assign bus.M           = w_m;
    assign bus.X_sel       = w_x_sel;
    assign bus.Y_sel       = w_y_sel;
    assign bus.Addr_sel    = w_addr_sel;
    assign bus.PC_En       = w_pc_en;
    assign bus.Acc_En      = w_acc_en;
    assign bus.IR_En       = w_ir_en;
    assign bus.Rd          = w_rd;
    assign bus.Wr          = w_wr;
    assign bus.State       = r_state;
    assign bus.Illegal     = r_illegal;
    assign bus.Instr_Count = r_cnt;
endmodule

// File: tb/tb_mu0_control.sv
// Directed bench for mu0_control: decode per state/opcode, halt,
// illegal, reset and counter saturation.
module tb_mu0_control;
    logic Clk;
    logic nReset;
    logic nReset_s;
    int   total;
    int   bad;

    mu0_control_if #(.CNT_W(16)) b ();
    mu0_control_if #(.CNT_W(3))  s ();

    mu0_control #(.CNT_W(16)) dut (
        .Clk    (Clk),
        .nReset (nReset),
        .bus    (b.slave)
    );

    mu0_control #(.CNT_W(3)) dut_s (
        .Clk    (Clk),
        .nReset (nReset_s),
        .bus    (s.slave)
    );

    // {M, X_sel, Y_sel, Addr_sel, PC_En, Acc_En, IR_En, Rd, Wr}
    logic [9:0] ctl;
    assign ctl = {b.M, b.X_sel, b.Y_sel, b.Addr_sel,
                  b.PC_En, b.Acc_En, b.IR_En, b.Rd, b.Wr};

    localparam logic [9:0] C_FETCH = 10'b10_1_0_0_1_0_1_1_0;
    localparam logic [9:0] C_LDA   = 10'b00_0_0_1_0_1_0_1_0;
    localparam logic [9:0] C_STA   = 10'b00_0_0_1_0_0_0_0_1;
    localparam logic [9:0] C_ADD   = 10'b01_0_0_1_0_1_0_1_0;
    localparam logic [9:0] C_SUB   = 10'b11_0_0_1_0_1_0_1_0;
    localparam logic [9:0] C_JMP   = 10'b00_0_1_0_1_0_0_0_0;
    localparam logic [9:0] C_NONE  = 10'b00_0_0_0_0_0_0_0_0;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        nReset   = 1'b0;
        nReset_s = 1'b0;
        b.F = 4'h0; b.N = 1'b0; b.Z = 1'b0;
        s.F = 4'h0; s.N = 1'b0; s.Z = 1'b0;

        tick();
        chk("rst_forced_ctl", 32'(ctl), 32'(C_NONE));
        tick();
        chk("rst_state", 32'(b.State), 32'h0);
        chk("rst_cnt", 32'(b.Instr_Count), 32'h0);
        chk("rst_illegal", 32'(b.Illegal), 32'h0);
        nReset = 1'b1;
        #1;
        chk("fetch0_ctl", 32'(ctl), 32'(C_FETCH));

        tick();
        chk("exec0_state", 32'(b.State), 32'h1);
        chk("lda_ctl", 32'(ctl), 32'(C_LDA));
        tick();
        chk("fetch1_state", 32'(b.State), 32'h0);
        chk("cnt_1", 32'(b.Instr_Count), 32'h1);
        tick();
        chk("exec1_state", 32'(b.State), 32'h1);
        tick();
        chk("cnt_2", 32'(b.Instr_Count), 32'h2);
        chk("fetch2_ctl", 32'(ctl), 32'(C_FETCH));

        b.F = 4'h2;
        tick();
        chk("add_ctl", 32'(ctl), 32'(C_ADD));
        b.F = 4'h3; #1;
        chk("sub_ctl", 32'(ctl), 32'(C_SUB));
        b.F = 4'h1; #1;
        chk("sta_ctl", 32'(ctl), 32'(C_STA));
        b.F = 4'h5; b.N = 1'b1; #1;
        chk("jge_n1", 32'(ctl), 32'(C_NONE));
        b.N = 1'b0; #1;
        chk("jge_n0", 32'(ctl), 32'(C_JMP));
        b.F = 4'h6; b.Z = 1'b1; #1;
        chk("jne_z1", 32'(ctl), 32'(C_NONE));
        b.Z = 1'b0; #1;
        chk("jne_z0", 32'(ctl), 32'(C_JMP));
        b.F = 4'h4; #1;
        chk("jmp_ctl", 32'(ctl), 32'(C_JMP));
        b.F = 4'h7; #1;
        chk("stp_ctl", 32'(ctl), 32'(C_NONE));

        tick();
        chk("stp_halt", 32'(b.State), 32'h2);
        chk("stp_cnt", 32'(b.Instr_Count), 32'h3);
        chk("stp_illegal", 32'(b.Illegal), 32'h0);
        b.F = 4'h0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("halt_hold", 32'(b.State), 32'h2);
            chk("halt_ctl", 32'(ctl), 32'(C_NONE));
        end
        chk("halt_cnt", 32'(b.Instr_Count), 32'h3);

        nReset = 1'b0;
        tick();
        chk("rst2_state", 32'(b.State), 32'h0);
        chk("rst2_cnt", 32'(b.Instr_Count), 32'h0);
        nReset = 1'b1;
        b.F = 4'hA;
        tick();
        chk("ill_exec_ctl", 32'(ctl), 32'(C_NONE));
        tick();
        chk("ill_halt", 32'(b.State), 32'h2);
        chk("ill_flag", 32'(b.Illegal), 32'h1);
        chk("ill_cnt", 32'(b.Instr_Count), 32'h1);
        tick();
        chk("ill_sticky", 32'(b.Illegal), 32'h1);

        nReset = 1'b0;
        tick();
        chk("ill_clear", 32'(b.Illegal), 32'h0);
        nReset = 1'b1;
        b.F = 4'h2;
        tick();
        chk("mid_add_ctl", 32'(ctl), 32'(C_ADD));
        nReset = 1'b0; #1;
        chk("mid_forced_ctl", 32'(ctl), 32'(C_NONE));
        tick();
        chk("mid_state", 32'(b.State), 32'h0);
        chk("mid_cnt", 32'(b.Instr_Count), 32'h0);
        chk("mid_rst_ctl", 32'(ctl), 32'(C_NONE));
        nReset = 1'b1;

        chk("sat_rst_cnt", 32'(s.Instr_Count), 32'h0);
        nReset_s = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            tick();
            chk("sat_cnt", 32'(s.Instr_Count), (i > 7) ? 32'h7 : 32'(i));
        end
        chk("sat_state", 32'(s.State), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mu0_control.md
Name: mu0_control

Overview:
- Control unit for the MU0 datapath; sits directly upstream of mu0_alu and drives its function select M[1:0].
- Two-phase fetch/execute FSM plus a halt state. Decodes the 4-bit opcode held in IR.
- Generates the datapath multiplexer selects, register enables and memory strobes.
- Keeps a saturating count of executed instructions for bench and debug visibility.

Parameters:
CNT_W, 16, width of the Instr_Count register.

Ports:
Clk  input  1  system clock; all state updates on the rising edge.
nReset  input  1  synchronous, active-low reset.
F  input  4  opcode field IR[15:12].
N  input  1  accumulator negative flag (ACC[15]).
Z  input  1  accumulator zero flag (ACC == 0).
M  output  2  ALU function: 00 = Y, 01 = X+Y, 10 = X+1, 11 = X-Y.
X_sel  output  1  ALU X source: 0 = ACC, 1 = PC.
Y_sel  output  1  ALU Y source: 0 = memory data, 1 = IR[11:0] zero-extended.
Addr_sel  output  1  memory address: 0 = PC, 1 = IR[11:0].
PC_En  output  1  PC load enable.
Acc_En  output  1  ACC load enable.
IR_En  output  1  IR load enable.
Rd  output  1  memory read strobe.
Wr  output  1  memory write strobe.
State  output  2  00 = FETCH, 01 = EXECUTE, 10 = HALT.
Illegal  output  1  sticky flag; set by an undefined opcode.
Instr_Count  output  CNT_W  number of executed instructions, saturating.

Behaviour:
- Clock and reset: one clock (Clk). Reset is synchronous and active-low (nReset); it is sampled only on the rising edge of Clk.
- Reset:
  - nReset = 0 at an edge sets State = FETCH, Illegal = 0, Instr_Count = 0.
  - This applies from any state, including mid-EXECUTE and HALT.
  - While nReset = 0, PC_En, Acc_En, IR_En, Rd and Wr are forced to 0, and M, X_sel, Y_sel and Addr_sel are forced to 0.
- Output timing: outputs are combinational decode of State, F, N and Z. There are no registered outputs other than State, Illegal and Instr_Count.
- Output defaults: any output not listed for a case below is 0.
- FETCH state:
  - Outputs: Addr_sel = 0, Rd = 1, IR_En = 1, X_sel = 1, M = 10, PC_En = 1.
  - Next state: EXECUTE.
- EXECUTE state, decode by F:
  - 0 LDA: Addr_sel = 1, Rd = 1, Y_sel = 0, M = 00, Acc_En = 1.
  - 1 STA: Addr_sel = 1, Wr = 1, X_sel = 0.
  - 2 ADD: Addr_sel = 1, Rd = 1, X_sel = 0, Y_sel = 0, M = 01, Acc_En = 1.
  - 3 SUB: as ADD but M = 11.
  - 4 JMP: Y_sel = 1, M = 00, PC_En = 1.
  - 5 JGE: JMP outputs if N = 0; otherwise all enables 0.
  - 6 JNE: JMP outputs if Z = 0; otherwise all enables 0.
  - 7 STP: all enables 0; next state HALT.
  - 8 to F (undefined): all enables 0; Illegal <= 1; next state HALT.
  - All other opcodes: next state FETCH.
- EXECUTE timing: N and Z are sampled combinationally during EXECUTE. They reflect ACC as it stood before this instruction.
- Instr_Count:
  - Increments by 1 at the edge that leaves EXECUTE, for every opcode including STP and undefined ones.
  - Saturates at 2^CNT_W - 1; no wrap-around.
- HALT state:
  - All enables and strobes are 0; M = 00.
  - State holds until reset. Instr_Count and Illegal hold.
- Latency: every instruction takes exactly 2 cycles (FETCH, then EXECUTE). No wait states.
- Strobes: Rd and Wr are never both 1 in the same cycle.

Test Plan:
- Reset then run: hold nReset = 0 for 2 edges, then release with F = 0. Required: State sequence 00, 01, 00, 01; FETCH shows M = 10, X_sel = 1, PC_En = IR_En = Rd = 1; EXECUTE shows Acc_En = 1, M = 00, Addr_sel = 1; Instr_Count = 2 after 4 cycles.
- ALU select per opcode: in EXECUTE with F = 2, then 3. Required: M = 01 then M = 11, X_sel = 0, Acc_En = 1 in both. With F = 1: Wr = 1, Rd = 0, Acc_En = 0.
- Conditional jumps:
  - F = 5, N = 1: PC_En = 0. F = 5, N = 0: PC_En = 1, Y_sel = 1, M = 00.
  - F = 6, Z = 1: PC_En = 0. F = 6, Z = 0: PC_En = 1.
- Halt and illegal:
  - F = 7 in EXECUTE: State = 10 next cycle and stays for 10 cycles with all enables 0; Illegal = 0.
  - Repeat after reset with F = 4'hA: State = 10 and Illegal = 1.
- Reset mid-operation: assert nReset = 0 while in EXECUTE with F = 2. Required: enables 0 immediately; State = 00 and Instr_Count = 0 after the edge; Illegal cleared if it was set.
- Saturation: with CNT_W = 3, run 10 non-halting instructions. Required: Instr_Count reaches 7 and holds at 7.
